// File: rtl/adc_capture_if.sv
// adc_capture_if: control, status and record read port of the ADC capture block.
// master = display/controller side, slave = adc_capture.
interface adc_capture_if #(
    parameter int DEPTH_LOG2 = 9
);
    logic                  arm;
    logic [7:0]            trig_level;
    logic                  trig_edge;
    logic                  busy;
    logic                  done;
    logic                  auto_trig;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [7:0]            rd_data;

    modport master (
        output arm, trig_level, trig_edge, rd_addr,
        input  busy, done, auto_trig, rd_data
    );

    modport slave (
        input  arm, trig_level, trig_edge, rd_addr,
        output busy, done, auto_trig, rd_data
    );
endinterface

// File: rtl/adc_capture.sv
// adc_capture: ADC sample clock generator, level/edge trigger and pre/post-trigger
// ring-buffer recorder with a trigger-aligned read port.
// Optional feature macro: ADC_CAPTURE_AUTO_TRIG_EN (forced trigger after
// AUTO_TIMEOUT samples in WAIT_TRIG, reported on auto_trig).
module adc_capture #(
    parameter int ADC_DIV      = 4,
    parameter int DEPTH_LOG2   = 9,
    parameter int PRE_TRIG     = 128,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   adc_din,
    output logic         adc_clk,
    adc_capture_if.slave bus
);
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int POST_LEN = DEPTH - PRE_TRIG - 1;
    localparam int DIV_W    = (ADC_DIV > 2) ? $clog2(ADC_DIV) : 1;

    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(ADC_DIV - 1);
    localparam logic [DIV_W-1:0]      DIV_HALF  = DIV_W'(ADC_DIV / 2);
    localparam logic [DEPTH_LOG2-1:0] PRE_LAST  = DEPTH_LOG2'(PRE_TRIG - 1);
    localparam logic [DEPTH_LOG2-1:0] POST_LAST = DEPTH_LOG2'(POST_LEN - 1);
    localparam logic [DEPTH_LOG2-1:0] PRE_OFS   = DEPTH_LOG2'(PRE_TRIG);

    // Configurations outside the legal range elaborate this empty marker block.
    if ((ADC_DIV < 2) || ((ADC_DIV % 2) != 0) || (PRE_TRIG < 1) ||
        (PRE_TRIG > DEPTH - 2) || (AUTO_TIMEOUT < 1)) begin : g_bad_config
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                state_q;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  adc_clk_q;
    logic [7:0]            cur_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, cnt_q, trig_ptr_q, start_ptr_q;
    logic                  busy_q, done_q;
    logic [7:0]            rd_data_q;
    logic [7:0]            mem_q [DEPTH];

    logic                  sample_stb_s;
    logic                  trig_hit_s;
    logic                  fire_s;
    logic                  wr_en_s;
    logic [DEPTH_LOG2-1:0] rd_phys_s;

`ifdef ADC_CAPTURE_AUTO_TRIG_EN
    localparam int TO_W = (AUTO_TIMEOUT > 2) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(AUTO_TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            auto_trig_q;
    logic            timeout_s;
`endif

    // Next divider count: wraps at ADC_DIV-1.
    always_comb begin
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    // Free-running divider; adc_clk is derived from the next count so it stays in phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            adc_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            adc_clk_q <= (div_cnt_d >= DIV_HALF);
        end
    end

    assign sample_stb_s = (div_cnt_q == DIV_LAST);

    // Sample register: cur_q holds the previous strobe's code, adc_din is the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= 8'h00;
        end else if (sample_stb_s) begin
            cur_q <= adc_din;
        end
    end

    // Trigger crossing between the previous sample (cur_q) and the arriving sample.
    always_comb begin
        if (bus.trig_edge) begin
            trig_hit_s = (cur_q > bus.trig_level) && (bus.trig_level >= adc_din);
        end else begin
            trig_hit_s = (cur_q < bus.trig_level) && (bus.trig_level <= adc_din);
        end
    end

`ifdef ADC_CAPTURE_AUTO_TRIG_EN
    // Timeout reached on the AUTO_TIMEOUT-th sample spent in WAIT_TRIG.
    always_comb begin
        if (to_cnt_q == TO_LAST) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end
`endif

    // Trigger event: real crossing, or forced by timeout when that feature is built in.
    always_comb begin
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
        fire_s = trig_hit_s | timeout_s;
`else
        fire_s = trig_hit_s;
`endif
    end

    // Buffer writes happen on every strobe while recording.
    always_comb begin
        case (state_q)
            S_PRE, S_WAIT, S_POST: wr_en_s = sample_stb_s;
            default:               wr_en_s = 1'b0;
        endcase
    end

    // Capture sequencer: arm handling, pre/post counting, trigger pointer and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            trig_ptr_q  <= '0;
            start_ptr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
            to_cnt_q    <= '0;
            auto_trig_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.arm) begin
                        wr_ptr_q <= '0;
                        cnt_q    <= '0;
                        done_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_PRE;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
                        to_cnt_q    <= '0;
                        auto_trig_q <= 1'b0;
`endif
                    end
                end
                S_PRE: begin
                    if (sample_stb_s) begin
                        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                        if (cnt_q == PRE_LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_WAIT;
                        end else begin
                            cnt_q <= cnt_q + DEPTH_LOG2'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (sample_stb_s) begin
                        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                        if (fire_s) begin
                            trig_ptr_q <= wr_ptr_q;
                            cnt_q      <= '0;
                            state_q    <= S_POST;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
                            auto_trig_q <= ~trig_hit_s;
`endif
                        end else begin
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
                            to_cnt_q <= to_cnt_q + TO_W'(1);
`endif
                        end
                    end
                end
                S_POST: begin
                    if (sample_stb_s) begin
                        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                        if (cnt_q == POST_LAST) begin
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            start_ptr_q <= trig_ptr_q - PRE_OFS;
                            state_q     <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + DEPTH_LOG2'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Record storage write port (no reset so it maps onto block RAM).
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= adc_din;
        end
    end

    assign rd_phys_s = start_ptr_q + bus.rd_addr;

    // Registered, trigger-aligned read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= mem_q[rd_phys_s];
        end
    end

    assign adc_clk      = adc_clk_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_data  = rd_data_q;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
    assign bus.auto_trig = auto_trig_q;
`else
    assign bus.auto_trig = 1'b0;
`endif
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed bench for adc_capture with a sample-history reference
// model and a read-data scoreboard queue.
module tb_adc_capture;
    localparam int DEPTH    = 512;
    localparam int PRE      = 128;
    localparam int POST_LEN = DEPTH - PRE - 1;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
    localparam int AUTO_TO = 16;
`else
    localparam int AUTO_TO = 4096;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] adc_din = 8'h00;
    logic       adc_clk;

    adc_capture_if #(.DEPTH_LOG2(9)) bus_if ();

    adc_capture #(
        .ADC_DIV(4), .DEPTH_LOG2(9), .PRE_TRIG(PRE), .AUTO_TIMEOUT(AUTO_TO)
    ) dut (
        .clk(clk), .rst(rst), .adc_din(adc_din), .adc_clk(adc_clk), .bus(bus_if)
    );

    always #5 clk = ~clk;

    // Reference divider phase: the DUT samples on the posedge leaving phase 3.
    int phase = 0;
    always @(posedge clk) begin
        if (rst) phase <= 0;
        else     phase <= (phase == 3) ? 0 : phase + 1;
    end

    int         checks = 0;
    int         failures = 0;
    logic [7:0] hist[$];
    logic [7:0] sb_q[$];
    int         trig_idx;
    bit         exp_auto;
    int         n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one ADC code so it is taken on the next sample strobe.
    task automatic put_sample(input logic [7:0] v);
        while (phase != 3) @(negedge clk);
        adc_din = v;
        hist.push_back(v);
        @(posedge clk);
    endtask

    task automatic do_arm();
        while (phase != 0) @(negedge clk);
        bus_if.arm = 1'b1;
        @(negedge clk);
        bus_if.arm = 1'b0;
    endtask

    // Reference model: locate the trigger sample in the history since arm.
    function automatic void model();
        logic [7:0] p, c, lvl;
        bit hit;
        trig_idx = -1;
        exp_auto = 1'b0;
        lvl = bus_if.trig_level;
        for (int i = PRE; i < hist.size(); i++) begin
            p = hist[i-1];
            c = hist[i];
            hit = bus_if.trig_edge ? ((p > lvl) && (lvl >= c)) : ((p < lvl) && (lvl <= c));
            if (hit) begin
                trig_idx = i;
                return;
            end
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
            if (i - PRE == AUTO_TO - 1) begin
                trig_idx = i;
                exp_auto = 1'b1;
                return;
            end
`endif
        end
    endfunction

    // kind 0: ramp, 1: 0xFF x1000 then 0x10, 2: constant 0x40
    task automatic capture(input int kind, input int max_n, input bit mid_arm, output int n_fed);
        logic [7:0] v;
        hist.delete();
        do_arm();
        chk("busy_after_arm", {31'd0, bus_if.busy}, 32'd1);
        chk("done_after_arm", {31'd0, bus_if.done}, 32'd0);
        n_fed = 0;
        while (n_fed < max_n) begin
            case (kind)
                0:       v = n_fed[7:0];
                1:       v = (n_fed < 1000) ? 8'hFF : 8'h10;
                default: v = 8'h40;
            endcase
            put_sample(v);
            n_fed++;
            @(negedge clk);
            if (bus_if.done === 1'b1) break;
            if (mid_arm && (n_fed == 50 || n_fed == 300)) begin
                do_arm();
                chk("arm_ignored_busy", {31'd0, bus_if.busy}, 32'd1);
            end
        end
    endtask

    task automatic verify_record(input int n_fed, input int exp_trig);
        int addrs [8] = '{0, 1, 127, 128, 129, 300, 510, 511};
        int idx;
        model();
        chk("trig_index", trig_idx, exp_trig);
        chk("samples_to_done", n_fed, exp_trig + POST_LEN + 1);
        chk("done_set", {31'd0, bus_if.done}, 32'd1);
        chk("busy_clear", {31'd0, bus_if.busy}, 32'd0);
        chk("auto_trig", {31'd0, bus_if.auto_trig}, {31'd0, exp_auto});
        if (trig_idx >= 0) begin
            for (int k = 0; k < 8; k++) begin
                bus_if.rd_addr = addrs[k][8:0];
                idx = trig_idx - PRE + addrs[k];
                sb_q.push_back((idx < hist.size()) ? hist[idx] : 8'h00);
                @(negedge clk);
                chk("rd_data", {24'd0, bus_if.rd_data}, {24'd0, sb_q.pop_front()});
            end
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_adc_clk", {31'd0, adc_clk}, 32'd0);
        chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("rst_done", {31'd0, bus_if.done}, 32'd0);
        chk("rst_auto_trig", {31'd0, bus_if.auto_trig}, 32'd0);
        chk("rst_rd_data", {24'd0, bus_if.rd_data}, 32'd0);
    endtask

    initial begin
        bus_if.arm        = 1'b0;
        bus_if.trig_level = 8'h80;
        bus_if.trig_edge  = 1'b0;
        bus_if.rd_addr    = 9'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;

        // divider: adc_clk low for phases 0-1, high for 2-3
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("adc_clk_phase", {31'd0, adc_clk}, (phase >= 2) ? 32'd1 : 32'd0);
        end

        // rising trigger on a ramp, with arm pulses in PRE and POST
        capture(0, 2000, 1'b1, n);
        verify_record(n, 128);

        // falling trigger after ring wrap; arm from DONE restarts
        bus_if.trig_edge = 1'b1;
        capture(1, 2000, 1'b0, n);
        verify_record(n, 1000);

        // reset mid-POST, arm coincident with reset
        bus_if.trig_edge = 1'b0;
        capture(0, 200, 1'b0, n);
        chk("busy_mid_post", {31'd0, bus_if.busy}, 32'd1);
        rst = 1'b1;
        bus_if.arm = 1'b1;
        @(negedge clk);
        bus_if.arm = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        chk("adc_clk_restart_low", {31'd0, adc_clk}, 32'd0);
        chk("busy_after_rst_arm", {31'd0, bus_if.busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("adc_clk_restart_high", {31'd0, adc_clk}, 32'd1);

        // constant input below level: timeout or indefinite wait
        bus_if.trig_level = 8'h80;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
        capture(2, 2000, 1'b0, n);
        verify_record(n, PRE + AUTO_TO - 1);
`else
        capture(2, 10000, 1'b0, n);
        chk("no_trig_samples", n, 10000);
        chk("no_trig_busy", {31'd0, bus_if.busy}, 32'd1);
        chk("no_trig_done", {31'd0, bus_if.done}, 32'd0);
        chk("no_trig_auto", {31'd0, bus_if.auto_trig}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_capture.md
# adc_capture

Sampling front end for the oscilloscope path: generates the ADC sample clock, registers `adc_din`, detects a level/edge trigger and stores a pre/post-trigger record in an internal ring buffer. It is the receive-side counterpart of the multiwave DAC generator: the generator drives DAC code + write strobe out, this block clocks ADC codes in. The display side reads the frozen record through a trigger-aligned read port.

## Interface
- `ADC_DIV`, 4, clk cycles per ADC sample; even, ≥2
- `DEPTH_LOG2`, 9, record length = 2^DEPTH_LOG2 samples (512)
- `PRE_TRIG`, 128, samples kept before the trigger sample; 1 ≤ PRE_TRIG ≤ DEPTH−2
- `AUTO_TIMEOUT`, 4096, samples waited in WAIT_TRIG before forced trigger (macro-gated)
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `adc_din`  in  8  ADC output code
- `adc_clk`  out  1  ADC sample clock
- `arm`  in  1  single-cycle pulse, start a capture
- `trig_level`  in  8  trigger threshold, unsigned
- `trig_edge`  in  1  0 = rising, 1 = falling
- `busy`  out  1  capture in progress
- `done`  out  1  record complete and frozen
- `auto_trig`  out  1  last record ended by timeout
- `rd_addr`  in  DEPTH_LOG2  logical index, 0 = oldest pre-trigger sample
- `rd_data`  out  8  stored sample at `rd_addr`

## Operation
- Divider `div_cnt` counts 0..ADC_DIV−1 continuously; `adc_clk` = 0 for `div_cnt` < ADC_DIV/2, else 1 (registered). `sample_stb` = (`div_cnt` == ADC_DIV−1); on it `adc_din` is registered as `cur`, previous `cur` moves to `prev`.
- States: IDLE, PRE, WAIT_TRIG, POST, DONE. All state actions occur only on `sample_stb` except arm/reset.
- IDLE/DONE + `arm`: `wr_ptr`←0, counters cleared, `done`←0, `auto_trig`←0, `busy`←1, → PRE. `arm` in PRE/WAIT_TRIG/POST ignored.
- PRE: write `cur` at `wr_ptr`, `wr_ptr`++ (mod DEPTH); after PRE_TRIG writes → WAIT_TRIG.
- WAIT_TRIG: write each sample (ring wraps). Trigger when rising: `prev` < `trig_level` ≤ `cur`; falling: `prev` > `trig_level` ≥ `cur`. `prev` is valid only after ≥2 samples in the current capture (guaranteed by PRE_TRIG ≥ 1). On trigger: trigger sample is written, `trig_ptr`←its address, → POST.
- POST: write DEPTH−PRE_TRIG−1 further samples, then `busy`←0, `done`←1, `start_ptr`←`trig_ptr`−PRE_TRIG (mod DEPTH), → DONE. Buffer holds exactly DEPTH samples, trigger sample at logical index PRE_TRIG.
- DONE: no writes; `done` held until next `arm` or `rst`.
- Read: physical address = `start_ptr`+`rd_addr` (mod DEPTH, natural wrap of DEPTH_LOG2 bits). Read allowed in any state; contents meaningful only while `done`=1.
- Memory: single write port (clk), single registered read port; inferable as block RAM.

## Timing
- Reset values: `adc_clk` 0, `busy` 0, `done` 0, `auto_trig` 0, `rd_data` 0, state IDLE, `div_cnt` 0, pointers 0. Reset mid-capture aborts immediately; buffer contents undefined after.
- `rd_data` latency: 1 clk from `rd_addr`.
- `busy` rises the clk after `arm`; first write on the next `sample_stb`.
- `done` rises the clk after the `sample_stb` carrying the last POST write; `busy` falls same edge.
- `arm` coincident with `rst`: reset wins.
- Trigger on the sample that completes PRE is not evaluated (evaluation starts in WAIT_TRIG).

## Configuration
- `ADC_CAPTURE_AUTO_TRIG_EN` defined: WAIT_TRIG counts samples; at AUTO_TIMEOUT without trigger, the current sample is treated as the trigger sample and `auto_trig`←1 (held until next `arm`).
- Not defined: WAIT_TRIG waits indefinitely; `auto_trig` tied 0; no timeout counter.

## Test plan
- Reset: hold `rst` 3 clk mid-POST -> all outputs at reset values, state IDLE, `adc_clk` restarts low.
- Divider: ADC_DIV=4 -> `adc_clk` period 4 clk, 50% duty; `sample_stb` once per 4 clk.
- Rising trigger: `trig_level`=0x80, ramp 0x00..0xFF step 1 per sample, `arm` -> `done`; `rd_data` at `rd_addr`=128 is 0x80, at 127 is 0x7F, at 0 is 0x00 (ramp wraps handled), `auto_trig`=0.
- Falling trigger with ring wrap: `trig_edge`=1, hold 0xFF for 1000 samples then 0x10 -> record index 127 = 0xFF, index 128 = 0x10, index 511 = 0x10.
- Auto trigger (macro on, AUTO_TIMEOUT=16): constant 0x40, level 0x80 -> `done` after 128+16+383 sample strobes, `auto_trig`=1; macro off -> `busy` stays 1 for 10000 samples.
- Arm while busy ignored; arm in DONE restarts: `done` drops next clk, new record overwrites.
